vx_tcu_drl_excep_ctrl: RTL and testbench
========================================

Name: VX_tcu_drl_excep_ctrl

Overview:
Step sequencer and sticky exception accumulator for one TCU dot-product lane group. It accepts a tile request (format, K-step count, tag) and issues one step token per K-chunk to the FEDP datapath under valid/ready. It collects the per-step fedp_excep_t returned by the exception stage and merges them with IEEE inf/NaN rules. It then returns one final exception record per tile to the TCU response path.

Parameters:
MAX_STEPS, 8, maximum K-steps per tile (power of 2, >=2); STEPW = $clog2(MAX_STEPS)
TAG_WIDTH, 4, width of the opaque request tag

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  tile request valid
req_ready  out  1  controller can accept a request
req_fmt  in  3  format ID (TCU_FP32_ID/FP16/BF16/FP8/BF8)
req_steps  in  STEPW  step count minus 1
req_tag  in  TAG_WIDTH  request tag
step_valid  out  1  step token to datapath
step_ready  in  1  datapath accepts step
step_idx  out  STEPW  index of current step
step_fmt  out  3  latched format
step_last  out  1  current step is the final one
excep_valid  in  1  per-step exception result valid (always accepted)
excep_in  in  $bits(fedp_excep_t)  per-step {sign,is_nan,is_inf}
rsp_valid  out  1  final result valid
rsp_ready  in  1  consumer accepts result
rsp_tag  out  TAG_WIDTH  echoed tag
rsp_excep  out  $bits(fedp_excep_t)  merged exception
busy  out  1  state != IDLE
err_unexp  out  1  one-cycle pulse: excep_valid dropped as unexpected

Behaviour:
- Single clock domain; all state updates on posedge clk.
- Reset: state=IDLE, counters=0, sticky bits=0. Outputs: req_ready=1, step_valid=0, rsp_valid=0, busy=0, err_unexp=0, step_idx=0, rsp_excep=0.
- Reset mid-operation aborts the tile with no response. Returns that arrive later in IDLE are dropped and pulse err_unexp.
- FSM states: IDLE, ISSUE, DRAIN, RESP.
- IDLE: req_ready=1. On req_valid, latch fmt, steps, tag; clear issue_cnt, ret_cnt and sticky bits {acc_nan, acc_pos, acc_neg}.
  - Unsupported fmt -> RESP directly with all-zero exception; no steps issued.
  - Otherwise -> ISSUE.
- ISSUE: step_valid=1, step_idx=issue_cnt, step_last=(issue_cnt==steps).
  - On step fire, issue_cnt++.
  - Fire with step_last -> DRAIN.
  - step_valid stays asserted and step_idx/fmt stay stable while step_ready=0.
- Result collection: excep_valid is counted in ISSUE and DRAIN only, and only while ret_cnt < issued steps.
  - Any other return (IDLE, RESP, or excess) is dropped and pulses err_unexp the next cycle.
  - A return in the same cycle as a step fire counts against the post-fire issue count.
- Merge per accepted return:
  - acc_nan |= is_nan
  - acc_pos |= is_inf & ~sign
  - acc_neg |= is_inf & sign
- DRAIN -> RESP when ret_cnt == steps+1, including in the cycle the final return is accepted.
- RESP: rsp_valid=1 and held until rsp_ready.
  - rsp_excep.is_nan = acc_nan | (acc_pos & acc_neg)
  - rsp_excep.is_inf = (acc_pos | acc_neg) & ~is_nan
  - rsp_excep.sign = acc_neg & ~acc_pos
  - On fire -> IDLE. No back-to-back bypass: the next request is accepted one cycle after the response fire.
- Latency: with step_ready=1 and returns L cycles after issue, the response appears N+L+1 cycles after request acceptance for N steps.
- Counter widths are STEPW+1; wrap-around cannot occur.

Decomposition:
- VX_tcu_pkg:
  - state enum tcu_excep_state_e
  - existing fedp_excep_t
  - existing format ID constants
  - function tcu_excep_merge(acc, excep_in) shared with any future multi-lane merger
- Sub-module VX_tcu_excep_acc: the sticky accumulator plus final-record formatting, with clear/en inputs. The FSM stays in the top.

Test Plan:
- FP16, steps=3 (4 steps), step_ready=1, all returns zero, L=2 -> 4 step fires with idx 0..3, last on idx 3; rsp at cycle 7 with excep=000 and tag echoed.
- BF16, 2 steps, returns {+inf} then {-inf} -> rsp is_nan=1, is_inf=0, sign=0.
- FP8, 3 steps, returns -inf, 0, -inf -> is_inf=1, sign=1, is_nan=0. One NaN return instead -> is_nan=1.
- step_ready toggled 1,0,0,1 -> step_idx/fmt held stable during stall, no duplicate or skipped idx; rsp_ready held low 5 cycles -> rsp_valid/tag/excep stable, req_ready=0.
- req_fmt=7 -> no step_valid, rsp next cycle with excep=000. excep_valid in IDLE -> err_unexp pulses once, no state change.
- Reset asserted in ISSUE after 2 of 4 steps -> next cycle IDLE, all outputs at reset values. A late return then pulses err_unexp. A new request completes normally.

Source files
------------

// File: rtl/vx_tcu_drl_excep_ctrl_pkg.sv
// Shared types for the TCU dot-product step sequencer: exception record,
// format IDs, FSM states and the sticky inf/NaN merge helpers.
package vx_tcu_drl_excep_ctrl_pkg;

  localparam logic [2:0] TCU_FP32_ID = 3'd0;
  localparam logic [2:0] TCU_FP16_ID = 3'd1;
  localparam logic [2:0] TCU_BF16_ID = 3'd2;
  localparam logic [2:0] TCU_FP8_ID  = 3'd3;
  localparam logic [2:0] TCU_BF8_ID  = 3'd4;

  typedef struct packed {
    logic sign;
    logic is_nan;
    logic is_inf;
  } fedp_excep_t;

  typedef struct packed {
    logic acc_nan;
    logic acc_pos;
    logic acc_neg;
  } tcu_excep_acc_t;

  typedef enum logic [1:0] {
    TCU_EXCEP_IDLE,
    TCU_EXCEP_ISSUE,
    TCU_EXCEP_DRAIN,
    TCU_EXCEP_RESP
  } tcu_excep_state_e;

  function automatic logic tcu_fmt_supported(input logic [2:0] fmt);
    return (fmt == TCU_FP32_ID) || (fmt == TCU_FP16_ID) || (fmt == TCU_BF16_ID)
        || (fmt == TCU_FP8_ID)  || (fmt == TCU_BF8_ID);
  endfunction

  // Sticky merge of one per-step result; infinities are tracked per sign so
  // that +inf and -inf in the same tile can later resolve to NaN.
  function automatic tcu_excep_acc_t tcu_excep_merge(input tcu_excep_acc_t acc,
                                                     input fedp_excep_t    excep_in);
    tcu_excep_acc_t res;
    res.acc_nan = acc.acc_nan | excep_in.is_nan;
    res.acc_pos = acc.acc_pos | (excep_in.is_inf & ~excep_in.sign);
    res.acc_neg = acc.acc_neg | (excep_in.is_inf &  excep_in.sign);
    return res;
  endfunction

  function automatic fedp_excep_t tcu_excep_format(input tcu_excep_acc_t acc);
    fedp_excep_t res;
    res.is_nan = acc.acc_nan | (acc.acc_pos & acc.acc_neg);
    res.is_inf = (acc.acc_pos | acc.acc_neg) & ~res.is_nan;
    res.sign   = acc.acc_neg & ~acc.acc_pos;
    return res;
  endfunction

endpackage

// File: rtl/vx_tcu_drl_excep_ctrl_acc.sv
// Sticky exception accumulator for one tile plus formatting of the final
// exception record.
module vx_tcu_drl_excep_ctrl_acc
  import vx_tcu_drl_excep_ctrl_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           en,
  input  logic [$bits(fedp_excep_t)-1:0] excep_in,
  output logic [$bits(fedp_excep_t)-1:0] rsp_excep
);

  tcu_excep_acc_t acc;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= tcu_excep_merge(acc, fedp_excep_t'(excep_in));
    end
  end

  assign rsp_excep = tcu_excep_format(acc);

endmodule

// File: rtl/vx_tcu_drl_excep_ctrl.sv
// Step sequencer for one TCU lane group: issues one step token per K-chunk,
// collects per-step exceptions and returns one merged record per tile.
module vx_tcu_drl_excep_ctrl
  import vx_tcu_drl_excep_ctrl_pkg::*;
#(
  parameter  int MAX_STEPS = 8,
  parameter  int TAG_WIDTH = 4,
  localparam int STEPW     = $clog2(MAX_STEPS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [2:0]                     req_fmt,
  input  logic [STEPW-1:0]               req_steps,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  output logic                           step_valid,
  input  logic                           step_ready,
  output logic [STEPW-1:0]               step_idx,
  output logic [2:0]                     step_fmt,
  output logic                           step_last,
  input  logic                           excep_valid,
  input  logic [$bits(fedp_excep_t)-1:0] excep_in,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic [$bits(fedp_excep_t)-1:0] rsp_excep,
  output logic                           busy,
  output logic                           err_unexp
);

  localparam int CNTW = STEPW + 1;

  tcu_excep_state_e     state, state_n;
  logic [STEPW-1:0]     steps_q;
  logic [2:0]           fmt_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CNTW-1:0]      issue_cnt, issue_cnt_n;
  logic [CNTW-1:0]      ret_cnt, ret_cnt_n;
  logic [CNTW-1:0]      total_steps;
  logic                 req_fire, step_fire;
  logic                 ret_window, ret_accept, ret_drop;
  logic                 err_unexp_q;

  assign total_steps = CNTW'(steps_q) + CNTW'(1);

  assign req_ready  = (state == TCU_EXCEP_IDLE);
  assign step_valid = (state == TCU_EXCEP_ISSUE);
  assign rsp_valid  = (state == TCU_EXCEP_RESP);
  assign busy       = (state != TCU_EXCEP_IDLE);
  assign step_idx   = issue_cnt[STEPW-1:0];
  assign step_fmt   = fmt_q;
  assign step_last  = step_valid && (issue_cnt == CNTW'(steps_q));
  assign rsp_tag    = tag_q;
  assign err_unexp  = err_unexp_q;

  assign req_fire  = req_valid && req_ready;
  assign step_fire = step_valid && step_ready;

  // A return arriving with a step fire is judged against the post-fire count,
  // which lets a zero-latency datapath report in the issue cycle.
  assign issue_cnt_n = issue_cnt + CNTW'(step_fire);
  assign ret_window  = (state == TCU_EXCEP_ISSUE) || (state == TCU_EXCEP_DRAIN);
  assign ret_accept  = excep_valid && ret_window && (ret_cnt < issue_cnt_n);
  assign ret_drop    = excep_valid && !ret_accept;
  assign ret_cnt_n   = ret_cnt + CNTW'(ret_accept);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      TCU_EXCEP_IDLE: begin
        if (req_valid) begin
          state_n = tcu_fmt_supported(req_fmt) ? TCU_EXCEP_ISSUE : TCU_EXCEP_RESP;
        end
      end
      TCU_EXCEP_ISSUE: begin
        if (step_fire && step_last) state_n = TCU_EXCEP_DRAIN;
      end
      TCU_EXCEP_DRAIN: begin
        if (ret_cnt_n == total_steps) state_n = TCU_EXCEP_RESP;
      end
      TCU_EXCEP_RESP: begin
        if (rsp_ready) state_n = TCU_EXCEP_IDLE;
      end
      default: state_n = TCU_EXCEP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= TCU_EXCEP_IDLE;
      steps_q     <= '0;
      fmt_q       <= '0;
      tag_q       <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      state       <= state_n;
      err_unexp_q <= ret_drop;
      if (req_fire) begin
        steps_q   <= req_steps;
        fmt_q     <= req_fmt;
        tag_q     <= req_tag;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        issue_cnt <= issue_cnt_n;
        ret_cnt   <= ret_cnt_n;
      end
    end
  end

  vx_tcu_drl_excep_ctrl_acc u_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (req_fire),
    .en        (ret_accept),
    .excep_in  (excep_in),
    .rsp_excep (rsp_excep)
  );

endmodule

// File: tb/tb_vx_tcu_drl_excep_ctrl.sv
// Directed, table-driven bench for the TCU step sequencer / exception merger.
module tb_vx_tcu_drl_excep_ctrl;

  localparam int MAX_STEPS = 8;
  localparam int TAG_WIDTH = 4;
  localparam int STEPW     = $clog2(MAX_STEPS);
  localparam int NV        = 8;

  // {sign, is_nan, is_inf}
  localparam logic [2:0] Z    = 3'b000;
  localparam logic [2:0] PINF = 3'b001;
  localparam logic [2:0] NINF = 3'b101;
  localparam logic [2:0] QNAN = 3'b010;
  localparam logic [2:0] NALL = 3'b111;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_fmt;
  logic [STEPW-1:0]     req_steps;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 step_valid;
  logic                 step_ready;
  logic [STEPW-1:0]     step_idx;
  logic [2:0]           step_fmt;
  logic                 step_last;
  logic                 excep_valid;
  logic [2:0]           excep_in;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [2:0]           rsp_excep;
  logic                 busy;
  logic                 err_unexp;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]                fmt;
    logic [STEPW-1:0]          steps;
    logic [TAG_WIDTH-1:0]      tag;
    logic [MAX_STEPS-1:0][2:0] ret;
    logic [2:0]                exp_excep;
    int                        exp_fires;
  } vec_t;

  vec_t vecs [NV];

  always #5 clk = ~clk;

  vx_tcu_drl_excep_ctrl #(.MAX_STEPS(MAX_STEPS), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fmt     (req_fmt),
    .req_steps   (req_steps),
    .req_tag     (req_tag),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .step_idx    (step_idx),
    .step_fmt    (step_fmt),
    .step_last   (step_last),
    .excep_valid (excep_valid),
    .excep_in    (excep_in),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_tag     (rsp_tag),
    .rsp_excep   (rsp_excep),
    .busy        (busy),
    .err_unexp   (err_unexp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  32'(req_ready),  32'd1);
    check({tag, "_step_valid"}, 32'(step_valid), 32'd0);
    check({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_err_unexp"},  32'(err_unexp),  32'd0);
    check({tag, "_step_idx"},   32'(step_idx),   32'd0);
    check({tag, "_rsp_excep"},  32'(rsp_excep),  32'd0);
  endtask

  task automatic set_vec(input int i, input logic [2:0] fmt, input logic [STEPW-1:0] steps,
                         input logic [TAG_WIDTH-1:0] tag, input logic [MAX_STEPS-1:0][2:0] ret,
                         input logic [2:0] exp_excep, input int exp_fires);
    vecs[i].fmt       = fmt;
    vecs[i].steps     = steps;
    vecs[i].tag       = tag;
    vecs[i].ret       = ret;
    vecs[i].exp_excep = exp_excep;
    vecs[i].exp_fires = exp_fires;
  endtask

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_fmt     = '0;
    req_steps   = '0;
    req_tag     = '0;
    step_ready  = 1'b0;
    excep_valid = 1'b0;
    excep_in    = '0;
    rsp_ready   = 1'b0;
  endtask

  // Runs one tile: returns come back lat cycles after their step fire; with
  // stall set, step_ready is low in cycles 2 and 3; rsp_ready stays low for
  // the first hold cycles of the response.
  task automatic run_tile(input int vi, input int lat, input bit stall, input int hold);
    vec_t             v;
    int               fires, held, err_seen, exp_rsp;
    bit               done, prev_stalled;
    logic [STEPW-1:0] prev_idx;
    int               pend_cyc [$];
    logic [2:0]       pend_val [$];
    string            nm;
    v = vecs[vi];
    nm = $sformatf("v%0d_l%0d_s%0d", vi, lat, stall);
    fires = 0; held = 0; err_seen = 0; done = 1'b0; prev_stalled = 1'b0; prev_idx = '0;
    if (v.exp_fires == 0) exp_rsp = 1;
    else exp_rsp = v.exp_fires + ((lat == 0) ? 1 : lat) + 1 + (stall ? 2 : 0);
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      req_valid   = (c == 0);
      req_fmt     = v.fmt;
      req_steps   = v.steps;
      req_tag     = v.tag;
      step_ready  = !(stall && (c == 2 || c == 3));
      rsp_ready   = 1'b0;
      excep_valid = 1'b0;
      excep_in    = '0;
      #1;
      if (c == 0) check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
      if (c == 1) check({nm, "_busy"}, 32'(busy), 32'd1);
      if (err_unexp) err_seen++;
      if (prev_stalled) begin
        check({nm, "_stall_valid"}, 32'(step_valid), 32'd1);
        check({nm, "_stall_idx"},   32'(step_idx),   32'(prev_idx));
        check({nm, "_stall_fmt"},   32'(step_fmt),   32'(v.fmt));
      end
      prev_stalled = step_valid && !step_ready;
      prev_idx     = step_idx;
      if (step_valid && step_ready) begin
        check({nm, "_step_idx"},  32'(step_idx),  32'(fires));
        check({nm, "_step_last"}, 32'(step_last), 32'(fires == int'(v.steps)));
        check({nm, "_step_fmt"},  32'(step_fmt),  32'(v.fmt));
        pend_cyc.push_back(c + lat);
        pend_val.push_back(v.ret[fires % MAX_STEPS]);
        fires++;
      end
      if (pend_cyc.size() > 0 && pend_cyc[0] == c) begin
        void'(pend_cyc.pop_front());
        excep_valid = 1'b1;
        excep_in    = pend_val.pop_front();
      end
      if (rsp_valid) begin
        if (held == 0) check({nm, "_rsp_cycle"}, 32'(c), 32'(exp_rsp));
        check({nm, "_rsp_tag"},   32'(rsp_tag),   32'(v.tag));
        check({nm, "_rsp_excep"}, 32'(rsp_excep), 32'(v.exp_excep));
        if (held < hold) begin
          check({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
          held++;
        end else begin
          rsp_ready = 1'b1;
          done      = 1'b1;
        end
      end
      @(posedge clk);
    end
    check({nm, "_rsp_seen"},  32'(done),     32'd1);
    check({nm, "_fires"},     32'(fires),    32'(v.exp_fires));
    check({nm, "_no_unexp"},  32'(err_seen), 32'd0);
    check({nm, "_ret_drain"}, 32'(pend_cyc.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("por");

    //      idx fmt    steps   tag    returns (idx7 .. idx0)              expected  fires
    set_vec(0, 3'd1, 3'd3, 4'h5, {Z, Z, Z, Z, Z, Z, Z, Z},                3'b000, 4);
    set_vec(1, 3'd2, 3'd1, 4'hA, {Z, Z, Z, Z, Z, Z, NINF, PINF},          3'b010, 2);
    set_vec(2, 3'd3, 3'd2, 4'h3, {Z, Z, Z, Z, Z, NINF, Z, NINF},          3'b101, 3);
    set_vec(3, 3'd3, 3'd2, 4'hC, {Z, Z, Z, Z, Z, NINF, QNAN, NINF},       3'b110, 3);
    set_vec(4, 3'd7, 3'd2, 4'h9, {Z, Z, Z, Z, Z, NINF, NINF, NINF},       3'b000, 0);
    set_vec(5, 3'd0, 3'd7, 4'hF, {Z, Z, PINF, Z, Z, Z, Z, Z},             3'b001, 8);
    set_vec(6, 3'd4, 3'd0, 4'h1, {Z, Z, Z, Z, Z, Z, Z, NALL},             3'b110, 1);
    set_vec(7, 3'd2, 3'd1, 4'h2, {Z, Z, Z, Z, Z, Z, PINF, PINF},          3'b001, 2);

    for (int i = 0; i < NV; i++) run_tile(i, 2, 1'b0, 0);
    run_tile(2, 0, 1'b0, 0);
    run_tile(3, 1, 1'b0, 0);
    run_tile(0, 2, 1'b1, 5);

    // Unexpected return while idle.
    @(negedge clk);
    idle_inputs();
    excep_valid = 1'b1;
    excep_in    = NINF;
    @(posedge clk);
    @(negedge clk);
    excep_valid = 1'b0;
    #1;
    check("idle_err_pulse", 32'(err_unexp), 32'd1);
    check("idle_err_busy",  32'(busy),      32'd0);
    check("idle_err_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("idle_err_single", 32'(err_unexp), 32'd0);

    // Return while the response is pending must be dropped, not merged.
    @(negedge clk);
    req_valid = 1'b1; req_fmt = 3'd6; req_steps = 3'd1; req_tag = 4'h4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; excep_valid = 1'b1; excep_in = PINF;
    #1;
    check("resp_drop_valid", 32'(rsp_valid), 32'd1);
    check("resp_drop_nostep", 32'(step_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    excep_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    check("resp_drop_err",   32'(err_unexp), 32'd1);
    check("resp_drop_excep", 32'(rsp_excep), 32'd0);
    check("resp_drop_tag",   32'(rsp_tag),   32'h4);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("resp_drop_idle", 32'(req_ready), 32'd1);

    // Reset in the middle of a tile after two of four steps.
    @(negedge clk);
    req_valid = 1'b1; req_fmt = 3'd1; req_steps = 3'd3; req_tag = 4'h7; step_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_idx1", 32'(step_idx), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; step_ready = 1'b0; excep_valid = 1'b1; excep_in = NINF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; excep_valid = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    excep_valid = 1'b1; excep_in = NINF;
    @(posedge clk);
    @(negedge clk);
    excep_valid = 1'b0;
    #1;
    check("late_ret_err",  32'(err_unexp), 32'd1);
    check("late_ret_busy", 32'(busy),      32'd0);
    run_tile(0, 2, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
